// File: rtl/fios_pkg.sv
// Shared types and helpers for the FIOS BRAM sequencer and its operand FIFO.
package fios_pkg;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P  = 2'd1,
        A  = 2'd2,
        B  = 2'd3
    } op_sel_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        KICK    = 3'd2,
        COLLECT = 3'd3,
        DONE    = 3'd4
    } fios_state_t;

    typedef struct packed {
        op_sel_t     sel;
        logic [15:0] idx;
        logic [16:0] data;
    } op_word_t;

    localparam int BRAM_LAT = 1;

    function automatic int fios_s(input int width);
        return (width + 1) / 17 + 1;
    endfunction

endpackage

// File: rtl/fios_skid_fifo.sv
// Two-entry operand FIFO between BRAM read data and the core operand stream.
module fios_skid_fifo
    import fios_pkg::*;
(
    input  logic     clock_i,
    input  logic     reset_i,
    input  logic     in_valid_i,
    output logic     in_ready_o,
    input  op_word_t in_data_i,
    output logic     out_valid_o,
    input  logic     out_ready_i,
    output op_word_t out_data_o,
    output logic [1:0] occ_o
);

    op_word_t   mem_q [2];
    op_word_t   mem_d [2];
    logic [1:0] cnt_q, cnt_d;
    logic       push, pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[0];
    assign occ_o       = cnt_q;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // Head always lives in slot 0; a pop shifts slot 1 down.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        case ({push, pop})
            2'b01: begin
                mem_d[0] = mem_q[1];
                cnt_d    = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) mem_d[0] = in_data_i;
                else               mem_d[1] = in_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    mem_d[0] = in_data_i;
                end else begin
                    mem_d[0] = mem_q[1];
                    mem_d[1] = in_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fios_bram_sequencer.sv
// Streams p'0, p, a, b from BRAM into the FIOS core, then writes the result back.
// state   | meaning
// IDLE    | waiting for start_i
// LOAD    | reading operand words 0..3S and streaming them to the core
// KICK    | one-cycle core_start_o pulse
// COLLECT | writing result beats to BRAM words 0..S-1
// DONE    | done_o held until the next start_i
module fios_bram_sequencer
    import fios_pkg::*;
#(
    parameter int WIDTH = 4096
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        bram_en_o,
    output logic [3:0]  bram_we_o,
    output logic [31:0] bram_addr_o,
    output logic [31:0] bram_din_o,
    input  logic [31:0] bram_dout_i,
    output logic        op_valid_o,
    input  logic        op_ready_i,
    output logic [1:0]  op_sel_o,
    output logic [15:0] op_idx_o,
    output logic [16:0] op_data_o,
    output logic        core_start_o,
    input  logic        res_valid_i,
    output logic        res_ready_o,
    input  logic [16:0] res_data_i
);

    localparam int          S       = fios_s(WIDTH);
    localparam logic [15:0] S_M1    = 16'(S - 1);
    localparam logic [15:0] N_WORDS = 16'(3 * S + 1);

    fios_state_t state_q, state_d;
    logic [15:0] rd_idx_q, rd_idx_d;
    op_sel_t     iss_sel_q, iss_sel_d;
    logic [15:0] iss_idx_q, iss_idx_d;
    logic [15:0] res_cnt_q, res_cnt_d;
    logic        done_q, done_d;

    logic [BRAM_LAT-1:0] rvalid_q, rvalid_d;
    op_sel_t             rsel_q [BRAM_LAT];
    op_sel_t             rsel_d [BRAM_LAT];
    logic [15:0]         ridx_q [BRAM_LAT];
    logic [15:0]         ridx_d [BRAM_LAT];

    logic       start_acc, issue, op_pop, last_xfer, beat;
    logic [2:0] inflight, outstanding;
    logic [1:0] fifo_occ;
    logic       fifo_out_valid;
    op_word_t   fifo_head;
    logic       unused_fifo_in_ready;
    logic       unused_dout_hi;

    assign unused_dout_hi = |bram_dout_i[31:17];

    fios_skid_fifo u_fifo (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .in_valid_i  (rvalid_q[BRAM_LAT-1]),
        .in_ready_o  (unused_fifo_in_ready),
        .in_data_i   ({rsel_q[BRAM_LAT-1], ridx_q[BRAM_LAT-1], bram_dout_i[16:0]}),
        .out_valid_o (fifo_out_valid),
        .out_ready_i (op_ready_i),
        .out_data_o  (fifo_head),
        .occ_o       (fifo_occ)
    );

    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_LAT; i++) inflight = inflight + 3'(rvalid_q[i]);
    end

    // A word leaving the FIFO this cycle frees its slot, which keeps one read per cycle.
    assign op_pop      = fifo_out_valid & op_ready_i;
    assign outstanding = {1'b0, fifo_occ} + inflight - {2'b00, op_pop};
    assign issue       = (state_q == LOAD) && (rd_idx_q != N_WORDS) && (outstanding < 3'd2);
    assign last_xfer   = op_pop && (fifo_head.sel == B) && (fifo_head.idx == S_M1);
    assign beat        = (state_q == COLLECT) && res_valid_i;
    assign start_acc   = start_i && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_i) state_d = LOAD;
            LOAD:       if (last_xfer) state_d = KICK;
            KICK:       state_d = COLLECT;
            COLLECT:    if (beat && (res_cnt_q == S_M1)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = 1'b0;
        bram_en_o    = 1'b0;
        bram_we_o    = 4'h0;
        bram_addr_o  = '0;
        bram_din_o   = '0;
        core_start_o = 1'b0;
        res_ready_o  = 1'b0;
        case (state_q)
            LOAD: begin
                busy_o      = 1'b1;
                bram_en_o   = issue;
                bram_addr_o = {14'b0, rd_idx_q, 2'b00};
            end
            KICK: begin
                busy_o       = 1'b1;
                core_start_o = 1'b1;
            end
            COLLECT: begin
                busy_o      = 1'b1;
                res_ready_o = 1'b1;
                bram_en_o   = res_valid_i;
                bram_we_o   = res_valid_i ? 4'hf : 4'h0;
                bram_addr_o = {14'b0, res_cnt_q, 2'b00};
                bram_din_o  = {15'b0, res_data_i};
            end
            default: ;
        endcase
    end

    assign op_valid_o = fifo_out_valid;
    assign op_sel_o   = fifo_head.sel;
    assign op_idx_o   = fifo_head.idx;
    assign op_data_o  = fifo_head.data;
    assign done_o     = done_q;

    always_comb begin
        rd_idx_d  = rd_idx_q;
        iss_sel_d = iss_sel_q;
        iss_idx_d = iss_idx_q;
        res_cnt_d = res_cnt_q;
        done_d    = done_q;
        if (start_acc) begin
            rd_idx_d  = '0;
            iss_sel_d = P0;
            iss_idx_d = '0;
            res_cnt_d = '0;
            done_d    = 1'b0;
        end else begin
            if (issue) begin
                rd_idx_d = rd_idx_q + 16'd1;
                if (iss_sel_q == P0 || iss_idx_q == S_M1) begin
                    iss_sel_d = op_sel_t'(iss_sel_q + 2'd1);
                    iss_idx_d = '0;
                end else begin
                    iss_idx_d = iss_idx_q + 16'd1;
                end
            end
            if (beat) begin
                res_cnt_d = res_cnt_q + 16'd1;
                if (res_cnt_q == S_M1) done_d = 1'b1;
            end
        end
    end

    always_comb begin
        rvalid_d[0] = issue;
        rsel_d[0]   = iss_sel_q;
        ridx_d[0]   = iss_idx_q;
        for (int i = 1; i < BRAM_LAT; i++) begin
            rvalid_d[i] = rvalid_q[i-1];
            rsel_d[i]   = rsel_q[i-1];
            ridx_d[i]   = ridx_q[i-1];
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_idx_q  <= '0;
            iss_sel_q <= P0;
            iss_idx_q <= '0;
            res_cnt_q <= '0;
            done_q    <= 1'b0;
            rvalid_q  <= '0;
            for (int i = 0; i < BRAM_LAT; i++) begin
                rsel_q[i] <= P0;
                ridx_q[i] <= '0;
            end
        end else begin
            rd_idx_q  <= rd_idx_d;
            iss_sel_q <= iss_sel_d;
            iss_idx_q <= iss_idx_d;
            res_cnt_q <= res_cnt_d;
            done_q    <= done_d;
            rvalid_q  <= rvalid_d;
            for (int i = 0; i < BRAM_LAT; i++) begin
                rsel_q[i] <= rsel_d[i];
                ridx_q[i] <= ridx_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fios_bram_sequencer.sv
// Scoreboard bench: WIDTH=32 and WIDTH=4096 sequencers sharing one BRAM model.
module tb_fios_bram_sequencer;

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] idx;
        logic [16:0] data;
        logic        last;
    } op_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_v [2];
    logic        res_valid_v [2];
    logic        op_ready = 1'b1;
    logic        ready_hold = 1'b1;
    logic        bp_en = 1'b0;
    logic [16:0] res_data = '0;
    logic [31:0] dout = '0;

    logic        busy_w [2], done_w [2], en_w [2], core_w [2], opv_w [2], resr_w [2];
    logic [3:0]  we_w [2];
    logic [31:0] addr_w [2], din_w [2];
    logic [1:0]  sel_w [2];
    logic [15:0] idx_w [2];
    logic [16:0] data_w [2];

    logic [31:0] mem [0:1023];
    op_exp_t     op_q [$];
    wr_exp_t     wr_q [$];

    int cur = 0;
    int vectors = 0, errors = 0;
    int cyc = 0;
    int rd_cnt = 0, xfer_cnt = 0, core_cnt = 0, out_viol = 0;
    int rd_base = 0, xfer_base = 0, core_base = 0;
    int start_cyc = 0, last_xfer_cyc = -10, opv_rise_cyc = -10;
    logic opv_prev = 1'b0;
    int bp_i = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fios_bram_sequencer #(.WIDTH(32)) dut_s (
        .clock_i(clk), .reset_i(rst_n), .start_i(start_v[0]),
        .busy_o(busy_w[0]), .done_o(done_w[0]),
        .bram_en_o(en_w[0]), .bram_we_o(we_w[0]), .bram_addr_o(addr_w[0]),
        .bram_din_o(din_w[0]), .bram_dout_i(dout),
        .op_valid_o(opv_w[0]), .op_ready_i(op_ready), .op_sel_o(sel_w[0]),
        .op_idx_o(idx_w[0]), .op_data_o(data_w[0]), .core_start_o(core_w[0]),
        .res_valid_i(res_valid_v[0]), .res_ready_o(resr_w[0]), .res_data_i(res_data)
    );

    fios_bram_sequencer #(.WIDTH(4096)) dut_l (
        .clock_i(clk), .reset_i(rst_n), .start_i(start_v[1]),
        .busy_o(busy_w[1]), .done_o(done_w[1]),
        .bram_en_o(en_w[1]), .bram_we_o(we_w[1]), .bram_addr_o(addr_w[1]),
        .bram_din_o(din_w[1]), .bram_dout_i(dout),
        .op_valid_o(opv_w[1]), .op_ready_i(op_ready), .op_sel_o(sel_w[1]),
        .op_idx_o(idx_w[1]), .op_data_o(data_w[1]), .core_start_o(core_w[1]),
        .res_valid_i(res_valid_v[1]), .res_ready_o(resr_w[1]), .res_data_i(res_data)
    );

    // BRAM model: one-cycle registered read, read-before-write.
    always @(posedge clk) begin
        if (en_w[cur]) begin
            dout <= mem[addr_w[cur][11:2]];
            if (we_w[cur] == 4'hf) mem[addr_w[cur][11:2]] = din_w[cur];
        end
    end

    always @(posedge clk) if (rst_n && en_w[cur] && we_w[cur] == 4'h0) rd_cnt++;

    always @(posedge clk) begin
        #1;
        op_ready = bp_en ? (bp_i == 0 || bp_i == 3) : ready_hold;
        bp_i = (bp_i + 1) % 4;
    end

    // Monitor: operand stream, core kick and BRAM writes against the queues.
    always @(negedge clk) begin : mon
        op_exp_t e;
        wr_exp_t w;
        if (rst_n) begin
            if ((rd_cnt - rd_base) - (xfer_cnt - xfer_base) > 2) out_viol++;
            if (opv_w[cur] && !opv_prev) opv_rise_cyc = cyc;
            if (opv_w[cur] && op_ready) begin
                vectors++;
                if (op_q.size() == 0) begin
                    errors++;
                    $display("FAIL op_unexpected got sel=%0d idx=%0d data=%05h exp=no word",
                             sel_w[cur], idx_w[cur], data_w[cur]);
                end else begin
                    e = op_q.pop_front();
                    if (sel_w[cur] !== e.sel || idx_w[cur] !== e.idx || data_w[cur] !== e.data) begin
                        errors++;
                        $display("FAIL op_word got sel=%0d idx=%0d data=%05h exp sel=%0d idx=%0d data=%05h",
                                 sel_w[cur], idx_w[cur], data_w[cur], e.sel, e.idx, e.data);
                    end
                    if (e.last) last_xfer_cyc = cyc;
                end
                xfer_cnt++;
            end
            if (core_w[cur]) begin
                core_cnt++;
                vectors++;
                if (cyc != last_xfer_cyc + 1) begin
                    errors++;
                    $display("FAIL core_start_cycle got=%0d exp=%0d", cyc, last_xfer_cyc + 1);
                end
            end
            if (en_w[cur] && we_w[cur] != 4'h0) begin
                vectors++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL bram_write_unexpected got addr=%h din=%h exp=no write",
                             addr_w[cur], din_w[cur]);
                end else begin
                    w = wr_q.pop_front();
                    if (addr_w[cur] !== w.addr || din_w[cur] !== w.data || we_w[cur] !== 4'hf) begin
                        errors++;
                        $display("FAIL bram_write got addr=%h din=%h we=%h exp addr=%h din=%h we=f",
                                 addr_w[cur], din_w[cur], we_w[cur], w.addr, w.data);
                    end
                end
            end
        end
        opv_prev = opv_w[cur];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {25'b0, busy_w[cur], done_w[cur], en_w[cur], opv_w[cur],
                             core_w[cur], resr_w[cur], |we_w[cur]}, 32'h0);
        chk({tag, "_addr"}, addr_w[cur], 32'h0);
        chk({tag, "_din"}, din_w[cur], 32'h0);
        chk({tag, "_op_selidx"}, {14'b0, sel_w[cur], idx_w[cur]}, 32'h0);
        chk({tag, "_op_data"}, {15'b0, data_w[cur]}, 32'h0);
    endtask

    task automatic load_spec(input logic [16:0] off);
        mem[0] = {15'b0, 17'h1ABCD ^ off};
        mem[1] = {15'b0, 17'h00011 + off};
        mem[2] = {15'b0, 17'h00022 + off};
        mem[3] = {15'b0, 17'h00033 + off};
        mem[4] = {15'b0, 17'h00044 + off};
        mem[5] = {15'b0, 17'h00055 + off};
        mem[6] = {15'b0, 17'h00066 + off};
    endtask

    task automatic push_ops(input int s);
        op_exp_t e;
        for (int j = 0; j <= 3 * s; j++) begin
            e.sel  = (j == 0) ? 2'd0 : 2'((j - 1) / s + 1);
            e.idx  = (j == 0) ? 16'd0 : 16'((j - 1) % s);
            e.data = mem[j][16:0];
            e.last = (j == 3 * s);
            op_q.push_back(e);
        end
    endtask

    task automatic start_run(input int s);
        push_ops(s);
        rd_base   = rd_cnt;
        xfer_base = xfer_cnt;
        core_base = core_cnt;
        @(negedge clk);
        start_v[cur] = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start_v[cur] = 1'b0;
        chk("busy_after_start", {31'b0, busy_w[cur]}, 32'h1);
        chk("done_cleared_on_start", {31'b0, done_w[cur]}, 32'h0);
    endtask

    task automatic finish_run(input int s, input int mult, input int add, input bit timing);
        int n = 0;
        logic [16:0] r;
        wr_exp_t w;
        while (core_cnt == core_base && n < 4000) begin
            @(posedge clk);
            n++;
        end
        vectors++;
        if (core_cnt == core_base) begin
            errors++;
            $display("FAIL kick_timeout got=no core_start exp=core_start within 4000 cycles");
            return;
        end
        if (timing) chk("last_xfer_edge", last_xfer_cyc, start_cyc + 3 * s + 2);
        #1;
        for (int k = 0; k < s; k++) begin
            r = 17'((k * mult + add) % 131072);
            res_valid_v[cur] = 1'b1;
            res_data = r;
            w.addr = 32'(k * 4);
            w.data = {15'b0, r};
            wr_q.push_back(w);
            @(posedge clk);
            #1;
        end
        res_valid_v[cur] = 1'b0;
        chk("done_after_last_beat", {31'b0, done_w[cur]}, 32'h1);
        chk("busy_in_done", {31'b0, busy_w[cur]}, 32'h0);
        chk("core_start_pulses", core_cnt - core_base, 1);
        chk("ops_left", op_q.size(), 0);
        chk("writes_left", wr_q.size(), 0);
        chk("mem_res_first", mem[0], {15'b0, 17'(add % 131072)});
        chk("mem_res_last", mem[s - 1], {15'b0, 17'(((s - 1) * mult + add) % 131072)});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w242;
        int n;
        start_v[0] = 0; start_v[1] = 0;
        res_valid_v[0] = 0; res_valid_v[1] = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        #22;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // basic run, spec operands
        load_spec(17'h0);
        start_run(2);
        finish_run(2, 2, 32'h1FFFF, 1'b1);
        chk("first_word_cycle", opv_rise_cyc, start_cyc + 2);
        chk("basic_word0", mem[0], 32'h0001FFFF);
        chk("basic_word1", mem[1], 32'h00000001);

        // start during LOAD and a stray result beat after DONE
        load_spec(17'h100);
        start_run(2);
        repeat (3) @(posedge clk);
        #1 start_v[cur] = 1'b1;
        @(posedge clk);
        #1 start_v[cur] = 1'b0;
        finish_run(2, 7, 5, 1'b0);
        res_valid_v[cur] = 1'b1;
        res_data = 17'h0ABCD;
        @(posedge clk);
        #1 res_valid_v[cur] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("no_write_word2", mem[2], 32'h00000122);
        chk("done_sticky", {31'b0, done_w[cur]}, 32'h1);

        // backpressure 1,0,0,1
        load_spec(17'h200);
        bp_en = 1'b1;
        start_run(2);
        finish_run(2, 3, 17'h10000, 1'b0);
        bp_en = 1'b0;
        chk("reads_outstanding_le2", out_viol, 0);

        // reset after the third operand transfer
        load_spec(17'h300);
        start_run(2);
        n = 0;
        while ((xfer_cnt - xfer_base) < 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("three_transfers", xfer_cnt - xfer_base, 3);
        #2 rst_n = 1'b0;
        #1 check_zero("midload_reset");
        op_q.delete();
        rd_base = rd_cnt;
        xfer_base = xfer_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_run(2);
        finish_run(2, 11, 9, 1'b1);

        // back-to-back from DONE with fresh contents
        load_spec(17'h1F000);
        start_run(2);
        finish_run(2, 13, 17'h0F0F0, 1'b1);

        // full width on the 4096-bit instance
        cur = 1;
        for (int j = 0; j < 727; j++) mem[j] = {15'h2A5A, 17'((j * 97 + 3) % 131072)};
        w242 = mem[242];
        start_run(242);
        finish_run(242, 613, 11, 1'b1);
        chk("full_word242_untouched", mem[242], w242);
        chk("full_transfers", xfer_cnt - xfer_base, 727);
        chk("full_reads", rd_cnt - rd_base, 727);
        chk("reads_outstanding_le2_end", out_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
